// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Multicycle HI/LO unit for a MIPS-style pipeline: MULT/MULTU, DIV/DIVU,
// MTHI and MTLO. The architectural HI and LO registers live here.
//
// Handshake: a request is 'start' high for one cycle together with op/a/b.
// It is accepted only while busy is low and flush is low; otherwise it is
// dropped silently. After acceptance busy stays high until the cycle after
// the done pulse. done is a one-cycle pulse, and hi/lo already hold the
// result in that cycle. There is no back-pressure on done.
//
// Configuration macro: MDU_DIV_EN
//   defined   - restoring divider present (DATA_W steps, one per cycle)
//   undefined - no DIV state or datapath; DIV/DIVU act as no-ops
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start      issue op for one cycle (honoured only when idle)
//   op[2:0]    0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a, b       rs / rt operands, captured when start is honoured
//   flush      pipeline cancel; aborts MUL/DIV, ignored in DONE
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle completion pulse
//   hi, lo     architectural HI / LO registers
//   dbg_state  current FSM state encoding (for checkers)
// ---------------------------------------------------------------------------
module mul_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic [1:0]        dbg_state
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
`ifdef MDU_DIV_EN
      S_DIV  = 2'd2,
`endif
      S_DONE = 2'd3
   } state_t;

   state_t state;

   assign dbg_state = state;

   // ------------------------------------------------------------------
   // Multiplier: operands are registered at start, the product is formed
   // from the registered copies during the MUL cycle. Extending both
   // operands to 2*DATA_W (sign or zero) makes the low 2*DATA_W bits of a
   // plain multiply correct for both signed and unsigned forms.
   // ------------------------------------------------------------------
   logic [DATA_W-1:0]   mul_a;
   logic [DATA_W-1:0]   mul_b;
   logic                mul_signed;
   logic [2*DATA_W-1:0] mul_ext_a;
   logic [2*DATA_W-1:0] mul_ext_b;
   logic [2*DATA_W-1:0] product;

   always_comb begin
      mul_ext_a = {{DATA_W{mul_signed & mul_a[DATA_W-1]}}, mul_a};
      mul_ext_b = {{DATA_W{mul_signed & mul_b[DATA_W-1]}}, mul_b};
      product   = mul_ext_a * mul_ext_b;
   end

`ifdef MDU_DIV_EN
   // ------------------------------------------------------------------
   // Restoring divider on magnitudes. quo starts as |a| and is shifted out
   // MSB-first into the partial remainder while quotient bits shift in.
   // Signs are applied on the final step: quotient negative when the
   // operand signs differ, remainder takes the sign of the dividend.
   // ------------------------------------------------------------------
   localparam logic [2:0] OP_DIV    = 3'd2;
   localparam logic [2:0] OP_DIVU   = 3'd3;
   localparam int         CNT_W     = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] dvs;
   logic              neg_q;
   logic              neg_r;
   logic [CNT_W-1:0]  step_cnt;

   logic              div_signed;
   logic [DATA_W-1:0] mag_a;
   logic [DATA_W-1:0] mag_b;
   logic [DATA_W:0]   trial;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] next_rem;
   logic [DATA_W-1:0] next_quo;

   always_comb begin
      div_signed = (op == OP_DIV);
      // |most-negative| = 2^(DATA_W-1) still fits as an unsigned magnitude
      mag_a      = (div_signed && a[DATA_W-1]) ? -a : a;
      mag_b      = (div_signed && b[DATA_W-1]) ? -b : b;
      trial      = {rem, quo[DATA_W-1]};
      diff       = trial - {1'b0, dvs};
      if (diff[DATA_W]) begin
         next_rem = trial[DATA_W-1:0];
         next_quo = {quo[DATA_W-2:0], 1'b0};
      end else begin
         next_rem = diff[DATA_W-1:0];
         next_quo = {quo[DATA_W-2:0], 1'b1};
      end
   end
`endif

   // ------------------------------------------------------------------
   // Control FSM with registered busy/done and the HI/LO registers.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         mul_a      <= '0;
         mul_b      <= '0;
         mul_signed <= 1'b0;
`ifdef MDU_DIV_EN
         rem        <= '0;
         quo        <= '0;
         dvs        <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         step_cnt   <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !flush) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        mul_a      <= a;
                        mul_b      <= b;
                        mul_signed <= (op == OP_MULT);
                        state      <= S_MUL;
                        busy       <= 1'b1;
                     end
`ifdef MDU_DIV_EN
                     OP_DIV, OP_DIVU: begin
                        busy <= 1'b1;
                        if (b != '0) begin
                           rem      <= '0;
                           quo      <= mag_a;
                           dvs      <= mag_b;
                           neg_q    <= div_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
                           neg_r    <= div_signed & a[DATA_W-1];
                           step_cnt <= '0;
                           state    <= S_DIV;
                        end else begin
                           // divide by zero: HI/LO untouched, complete at once
                           state <= S_DONE;
                           done  <= 1'b1;
                        end
                     end
`endif
                     OP_MTHI: begin
                        hi    <= a;
                        state <= S_DONE;
                        busy  <= 1'b1;
                        done  <= 1'b1;
                     end
                     OP_MTLO: begin
                        lo    <= a;
                        state <= S_DONE;
                        busy  <= 1'b1;
                        done  <= 1'b1;
                     end
                     default: begin
                        state <= S_DONE;
                        busy  <= 1'b1;
                        done  <= 1'b1;
                     end
                  endcase
               end
            end
            S_MUL: begin
               if (flush) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  {hi, lo} <= product;
                  state    <= S_DONE;
                  done     <= 1'b1;
               end
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
               if (flush) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  rem      <= next_rem;
                  quo      <= next_quo;
                  step_cnt <= step_cnt + 1'b1;
                  if (step_cnt == LAST_STEP) begin
                     lo    <= neg_q ? -next_quo : next_quo;
                     hi    <= neg_r ? -next_rem : next_rem;
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end
`endif
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
